obi_apb_arbiter: RTL and testbench

OBI_APB_ARBITER -- requirements
Module: obi_apb_arbiter

---
 rtl/obi_apb_arbiter_if.sv | 52 +++++
 rtl/obi_apb_arbiter.sv | 141 ++++++++++++++
 tb/tb_obi_apb_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/obi_apb_arbiter_if.sv
// -----------------------------------------------------------------------------
// obi_apb_arbiter_if
// Purpose : bundles the two OBI requester ports and the single OBI manager port
//           (toward the OBI-to-APB bridge) of obi_apb_arbiter.
// Signals : s_req_i/s_addr_i/s_we_i/s_be_i/s_wdata_i  per-requester address phase
//           s_gnt_o/s_rvalid_o/s_err_o/s_rdata_o        per-requester grant/response
//           m_req_o/m_addr_o/m_we_o/m_be_o/m_wdata_o    manager address phase
//           m_gnt_i/m_rvalid_i/m_err_i/m_rdata_i        bridge grant/response
// Modports: slave  - arbiter view (requests and bridge response in, grants out)
//           master - environment view (drives requesters and bridge)
// Index 0 is the core data port, index 1 the debug/DMA port.
// -----------------------------------------------------------------------------
interface obi_apb_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [1:0]             s_req_i;
  logic [1:0][ADDR_W-1:0] s_addr_i;
  logic [1:0]             s_we_i;
  logic [1:0][BE_W-1:0]   s_be_i;
  logic [1:0][DATA_W-1:0] s_wdata_i;
  logic [1:0]             s_gnt_o;
  logic [1:0]             s_rvalid_o;
  logic [1:0]             s_err_o;
  logic [1:0][DATA_W-1:0] s_rdata_o;

  logic                   m_req_o;
  logic [ADDR_W-1:0]      m_addr_o;
  logic                   m_we_o;
  logic [BE_W-1:0]        m_be_o;
  logic [DATA_W-1:0]      m_wdata_o;
  logic                   m_gnt_i;
  logic                   m_rvalid_i;
  logic                   m_err_i;
  logic [DATA_W-1:0]      m_rdata_i;

  modport slave (
    input  s_req_i, s_addr_i, s_we_i, s_be_i, s_wdata_i,
    output s_gnt_o, s_rvalid_o, s_err_o, s_rdata_o,
    output m_req_o, m_addr_o, m_we_o, m_be_o, m_wdata_o,
    input  m_gnt_i, m_rvalid_i, m_err_i, m_rdata_i
  );

  modport master (
    output s_req_i, s_addr_i, s_we_i, s_be_i, s_wdata_i,
    input  s_gnt_o, s_rvalid_o, s_err_o, s_rdata_o,
    input  m_req_o, m_addr_o, m_we_o, m_be_o, m_wdata_o,
    output m_gnt_i, m_rvalid_i, m_err_i, m_rdata_i
  );
endinterface

// File: rtl/obi_apb_arbiter.sv
// -----------------------------------------------------------------------------
// obi_apb_arbiter
// Purpose : arbitrates two OBI requesters onto one OBI manager port feeding an
//           OBI-to-APB bridge, with at most one transaction outstanding.
//           FSM: IDLE (arbitrate) -> ADDR (address phase) -> RESP (wait rvalid).
// Ports   : clk_i  - clock, rising edge
//           rst_i  - synchronous, active-high reset
//           bus    - obi_apb_arbiter_if.slave (requester and manager signals)
//           owner_o- current or most recent owner index (debug)
// Config  : OBI_APB_ARBITER_RR_EN defined   -> round-robin on ties
//           OBI_APB_ARBITER_RR_EN undefined -> fixed priority, port 0 wins ties
// -----------------------------------------------------------------------------
module obi_apb_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  obi_apb_arbiter_if.slave      bus,
  output logic                  owner_o
);
  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q,  last_d;
  logic              winner_s;
  logic [1:0]        owner_oh_s;
  logic              m_req_s;
  logic [1:0]        gnt_s, rvalid_s, err_s;
  logic [ADDR_W-1:0] addr_mux_s;
  logic [BE_W-1:0]   be_mux_s;
  logic [DATA_W-1:0] wdata_mux_s;

  assign owner_oh_s = owner_q ? 2'b10 : 2'b01;

  // Tie-break between the two requesters, evaluated only in IDLE.
`ifdef OBI_APB_ARBITER_RR_EN
  assign winner_s = (bus.s_req_i == 2'b11) ? ~last_q : bus.s_req_i[1];
`else
  assign winner_s = ~bus.s_req_i[0];
  logic last_unused_s;
  assign last_unused_s = last_q;
`endif

  // State, owner and round-robin history registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic and per-requester handshake routing.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    m_req_s  = 1'b0;
    gnt_s    = 2'b00;
    rvalid_s = 2'b00;
    err_s    = 2'b00;
    case (state_q)
      IDLE: begin
        // m_rvalid_i is deliberately ignored here: nothing is outstanding.
        if (|bus.s_req_i) begin
          owner_d = winner_s;
          state_d = ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (!bus.s_req_i[owner_q]) begin
          // Owner withdrew its request before the grant: abandon it.
          state_d = IDLE;
        end else begin
          m_req_s = 1'b1;
          gnt_s   = owner_oh_s & {2{bus.m_gnt_i}};
          if (bus.m_gnt_i) begin
`ifdef OBI_APB_ARBITER_RR_EN
            last_d = owner_q;
`endif
            if (bus.m_rvalid_i) begin
              // Grant and response in the same cycle.
              rvalid_s = owner_oh_s;
              err_s    = owner_oh_s & {2{bus.m_err_i}};
              state_d  = IDLE;
            end else begin
              state_d = RESP;
            end
          end else begin
            state_d = ADDR;
          end
        end
      end
      RESP: begin
        if (bus.m_rvalid_i) begin
          rvalid_s = owner_oh_s;
          err_s    = owner_oh_s & {2{bus.m_err_i}};
          state_d  = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Address-phase payload always follows the owner; only m_req_o qualifies it.
  assign addr_mux_s  = bus.s_addr_i[owner_q];
  assign be_mux_s    = bus.s_be_i[owner_q];
  assign wdata_mux_s = bus.s_wdata_i[owner_q];

  assign bus.m_addr_o  = addr_mux_s;
  assign bus.m_we_o    = bus.s_we_i[owner_q];
  assign bus.m_be_o    = be_mux_s;
  assign bus.m_wdata_o = wdata_mux_s;

  // Handshake outputs are forced low while reset is held, whatever the state.
  assign bus.m_req_o    = m_req_s & ~rst_i;
  assign bus.s_gnt_o    = gnt_s & {2{~rst_i}};
  assign bus.s_rvalid_o = rvalid_s & {2{~rst_i}};
  assign bus.s_err_o    = err_s & {2{~rst_i}};
  assign bus.s_rdata_o  = {2{bus.m_rdata_i}};
  assign owner_o        = owner_q & ~rst_i;

endmodule

// File: tb/tb_obi_apb_arbiter.sv
module tb_obi_apb_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic owner;
  int   n_checks = 0;
  int   n_fail   = 0;

  obi_apb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  obi_apb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus.slave),
    .owner_o(owner)
  );

  always #5 clk = ~clk;

  // Control snapshot: [7] m_req, [6:5] s_gnt, [4:3] s_rvalid, [2:1] s_err, [0] owner
  wire [7:0] ctl = {bus.m_req_o, bus.s_gnt_o, bus.s_rvalid_o, bus.s_err_o, owner};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    bus.s_req_i    = 2'b00;
    bus.s_addr_i   = '0;
    bus.s_we_i     = 2'b00;
    bus.s_be_i     = '0;
    bus.s_wdata_i  = '0;
    bus.m_gnt_i    = 1'b0;
    bus.m_rvalid_i = 1'b0;
    bus.m_err_i    = 1'b0;
    bus.m_rdata_i  = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.s_req_i = 2'b11; bus.m_gnt_i = 1'b1; bus.m_rvalid_i = 1'b1; bus.m_err_i = 1'b1;
    tick(); settle();
    n_checks++; if (ctl !== 8'b0_00_00_00_0) begin n_fail++; $display("FAIL reset_during: ctl got %b expected %b", ctl, 8'b0_00_00_00_0); end
    tick();
    idle_inputs(); rst = 1'b0; settle();
    n_checks++; if (ctl !== 8'b0_00_00_00_0) begin n_fail++; $display("FAIL reset_after: ctl got %b expected %b", ctl, 8'b0_00_00_00_0); end
    tick();
    bus.m_rvalid_i = 1'b1; bus.m_err_i = 1'b1; settle();
    n_checks++; if (ctl !== 8'b0_00_00_00_0) begin n_fail++; $display("FAIL idle_rvalid_ignored: ctl got %b expected %b", ctl, 8'b0_00_00_00_0); end
    tick();
    idle_inputs();
  endtask

  task automatic test_single_read();
    bus.s_req_i[0] = 1'b1; bus.s_addr_i[0] = 32'h0000_1000; bus.s_we_i[0] = 1'b0; bus.s_be_i[0] = 4'b1111;
    settle();
    n_checks++; if (ctl !== 8'b0_00_00_00_0) begin n_fail++; $display("FAIL rd_idle: ctl got %b expected %b", ctl, 8'b0_00_00_00_0); end
    tick();
    bus.m_gnt_i = 1'b1; settle();
    n_checks++; if (ctl !== 8'b1_01_00_00_0) begin n_fail++; $display("FAIL rd_addr: ctl got %b expected %b", ctl, 8'b1_01_00_00_0); end
    n_checks++; if ({bus.m_we_o, bus.m_addr_o} !== {1'b0, 32'h0000_1000}) begin n_fail++; $display("FAIL rd_addr_phase: got %h expected %h", {bus.m_we_o, bus.m_addr_o}, {1'b0, 32'h0000_1000}); end
    tick();
    bus.m_gnt_i = 1'b0; bus.s_req_i = 2'b00; bus.m_rvalid_i = 1'b1; bus.m_rdata_i = 32'hDEAD_BEEF; settle();
    n_checks++; if (ctl !== 8'b0_00_01_00_0) begin n_fail++; $display("FAIL rd_resp: ctl got %b expected %b", ctl, 8'b0_00_01_00_0); end
    n_checks++; if (bus.s_rdata_o !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL rd_rdata: got %h expected %h", bus.s_rdata_o, {32'hDEAD_BEEF, 32'hDEAD_BEEF}); end
    tick();
    bus.m_rvalid_i = 1'b0; settle();
    n_checks++; if (ctl !== 8'b0_00_00_00_0) begin n_fail++; $display("FAIL rd_back_idle: ctl got %b expected %b", ctl, 8'b0_00_00_00_0); end
    idle_inputs();
  endtask

  task automatic test_error_write();
    bus.s_req_i = 2'b10; bus.s_addr_i[1] = 32'h0000_3000; bus.s_we_i[1] = 1'b1;
    bus.s_be_i[1] = 4'b0011; bus.s_wdata_i[1] = 32'hA5A5_A5A5;
    settle();
    n_checks++; if (ctl !== 8'b0_00_00_00_0) begin n_fail++; $display("FAIL wr_idle: ctl got %b expected %b", ctl, 8'b0_00_00_00_0); end
    tick();
    bus.m_gnt_i = 1'b1; settle();
    n_checks++; if (ctl !== 8'b1_10_00_00_1) begin n_fail++; $display("FAIL wr_addr: ctl got %b expected %b", ctl, 8'b1_10_00_00_1); end
    n_checks++; if ({bus.m_we_o, bus.m_be_o, bus.m_wdata_o, bus.m_addr_o} !== {1'b1, 4'b0011, 32'hA5A5_A5A5, 32'h0000_3000}) begin
      n_fail++; $display("FAIL wr_addr_phase: got %h expected %h", {bus.m_we_o, bus.m_be_o, bus.m_wdata_o, bus.m_addr_o}, {1'b1, 4'b0011, 32'hA5A5_A5A5, 32'h0000_3000});
    end
    tick();
    bus.m_gnt_i = 1'b0; bus.s_req_i = 2'b00; bus.m_rvalid_i = 1'b1; bus.m_err_i = 1'b1; settle();
    n_checks++; if (ctl !== 8'b0_00_10_10_1) begin n_fail++; $display("FAIL wr_err_resp: ctl got %b expected %b", ctl, 8'b0_00_10_10_1); end
    tick();
    bus.m_rvalid_i = 1'b0; bus.m_err_i = 1'b0; settle();
    n_checks++; if (ctl !== 8'b0_00_00_00_1) begin n_fail++; $display("FAIL wr_back_idle: ctl got %b expected %b", ctl, 8'b0_00_00_00_1); end
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    bus.s_req_i = 2'b01; bus.s_addr_i[0] = 32'h0000_2000; settle();
    n_checks++; if (ctl !== 8'b0_00_00_00_1) begin n_fail++; $display("FAIL sc_idle: ctl got %b expected %b", ctl, 8'b0_00_00_00_1); end
    tick();
    bus.m_gnt_i = 1'b1; bus.m_rvalid_i = 1'b1; bus.m_rdata_i = 32'h1234_5678; settle();
    n_checks++; if (ctl !== 8'b1_01_01_00_0) begin n_fail++; $display("FAIL sc_gnt_rvalid: ctl got %b expected %b", ctl, 8'b1_01_01_00_0); end
    n_checks++; if (bus.s_rdata_o[0] !== 32'h1234_5678) begin n_fail++; $display("FAIL sc_rdata: got %h expected %h", bus.s_rdata_o[0], 32'h1234_5678); end
    tick();
    bus.s_req_i = 2'b00; bus.m_gnt_i = 1'b0; settle();
    n_checks++; if (ctl !== 8'b0_00_00_00_0) begin n_fail++; $display("FAIL sc_no_extra_rvalid: ctl got %b expected %b", ctl, 8'b0_00_00_00_0); end
    tick();
    idle_inputs();
  endtask

  task automatic test_drop_req();
    bus.s_req_i = 2'b01; tick();
    bus.s_req_i = 2'b00; settle();
    n_checks++; if (ctl !== 8'b0_00_00_00_0) begin n_fail++; $display("FAIL drop_addr: ctl got %b expected %b", ctl, 8'b0_00_00_00_0); end
    tick();
    bus.s_req_i = 2'b10; settle();
    n_checks++; if (ctl !== 8'b0_00_00_00_0) begin n_fail++; $display("FAIL drop_idle: ctl got %b expected %b", ctl, 8'b0_00_00_00_0); end
    tick();
    bus.m_gnt_i = 1'b1; settle();
    n_checks++; if (ctl !== 8'b1_10_00_00_1) begin n_fail++; $display("FAIL drop_next_owner: ctl got %b expected %b", ctl, 8'b1_10_00_00_1); end
    tick();
    bus.m_gnt_i = 1'b0; bus.s_req_i = 2'b00; bus.m_rvalid_i = 1'b1; settle();
    n_checks++; if (ctl !== 8'b0_00_10_00_1) begin n_fail++; $display("FAIL drop_resp: ctl got %b expected %b", ctl, 8'b0_00_10_00_1); end
    tick();
    idle_inputs();
  endtask

  task automatic test_stall();
    bus.s_req_i = 2'b01; bus.s_addr_i[0] = 32'h0000_4000; tick();
    bus.s_req_i = 2'b11; bus.m_gnt_i = 1'b1; settle();
    n_checks++; if (ctl !== 8'b1_01_00_00_0) begin n_fail++; $display("FAIL stall_addr: ctl got %b expected %b", ctl, 8'b1_01_00_00_0); end
    tick();
    // Bridge keeps gnt high but withholds rvalid for five cycles.
    bus.s_req_i = 2'b10;
    for (int k = 0; k < 5; k++) begin
      settle();
      n_checks++; if (ctl !== 8'b0_00_00_00_0) begin n_fail++; $display("FAIL stall_wait%0d: ctl got %b expected %b", k, ctl, 8'b0_00_00_00_0); end
      tick();
    end
    bus.m_rvalid_i = 1'b1; bus.m_rdata_i = 32'h0BAD_F00D; settle();
    n_checks++; if (ctl !== 8'b0_00_01_00_0) begin n_fail++; $display("FAIL stall_resp: ctl got %b expected %b", ctl, 8'b0_00_01_00_0); end
    tick();
    bus.m_rvalid_i = 1'b0; bus.m_gnt_i = 1'b0; settle();
    n_checks++; if (ctl !== 8'b0_00_00_00_0) begin n_fail++; $display("FAIL stall_idle: ctl got %b expected %b", ctl, 8'b0_00_00_00_0); end
    tick();
    bus.m_gnt_i = 1'b1; settle();
    n_checks++; if (ctl !== 8'b1_10_00_00_1) begin n_fail++; $display("FAIL stall_port1_gnt: ctl got %b expected %b", ctl, 8'b1_10_00_00_1); end
    tick();
    bus.m_gnt_i = 1'b0; bus.s_req_i = 2'b00; bus.m_rvalid_i = 1'b1; settle();
    n_checks++; if (ctl !== 8'b0_00_10_00_1) begin n_fail++; $display("FAIL stall_port1_resp: ctl got %b expected %b", ctl, 8'b0_00_10_00_1); end
    tick();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic e, prev;
    logic [1:0] oh;
    rst = 1'b1; bus.s_req_i = 2'b11; tick();
    rst = 1'b0;
    prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
`ifdef OBI_APB_ARBITER_RR_EN
      e = (i % 2 == 1);
`else
      e = 1'b0;
`endif
      oh = e ? 2'b10 : 2'b01;
      settle();
      n_checks++; if (ctl !== {1'b0, 2'b00, 2'b00, 2'b00, prev}) begin n_fail++; $display("FAIL b2b_idle%0d: ctl got %b expected %b", i, ctl, {1'b0, 2'b00, 2'b00, 2'b00, prev}); end
      tick();
      bus.m_gnt_i = 1'b1; settle();
      n_checks++; if (ctl !== {1'b1, oh, 2'b00, 2'b00, e}) begin n_fail++; $display("FAIL b2b_owner%0d: ctl got %b expected %b", i, ctl, {1'b1, oh, 2'b00, 2'b00, e}); end
      tick();
      bus.m_gnt_i = 1'b0; bus.m_rvalid_i = 1'b1; bus.m_rdata_i = 32'h0000_0100 + i; settle();
      n_checks++; if (ctl !== {1'b0, 2'b00, oh, 2'b00, e}) begin n_fail++; $display("FAIL b2b_resp%0d: ctl got %b expected %b", i, ctl, {1'b0, 2'b00, oh, 2'b00, e}); end
      tick();
      bus.m_rvalid_i = 1'b0;
      prev = e;
    end
    idle_inputs();
  endtask

  task automatic test_reset_in_resp();
    settle(); tick();
    bus.s_req_i = 2'b01; bus.s_addr_i[0] = 32'h0000_5000; tick();
    bus.m_gnt_i = 1'b1; tick();
    bus.m_gnt_i = 1'b0; bus.s_req_i = 2'b11; rst = 1'b1; bus.m_rvalid_i = 1'b1; settle();
    n_checks++; if (ctl !== 8'b0_00_00_00_0) begin n_fail++; $display("FAIL rst_resp_during: ctl got %b expected %b", ctl, 8'b0_00_00_00_0); end
    tick();
    rst = 1'b0; settle();
    n_checks++; if (ctl !== 8'b0_00_00_00_0) begin n_fail++; $display("FAIL rst_resp_late_rvalid: ctl got %b expected %b", ctl, 8'b0_00_00_00_0); end
    tick();
    bus.m_rvalid_i = 1'b0; bus.m_gnt_i = 1'b1; settle();
    n_checks++; if (ctl !== 8'b1_01_00_00_0) begin n_fail++; $display("FAIL rst_first_arb: ctl got %b expected %b", ctl, 8'b1_01_00_00_0); end
    tick();
    bus.m_gnt_i = 1'b0; bus.s_req_i = 2'b00; bus.m_rvalid_i = 1'b1; settle();
    n_checks++; if (ctl !== 8'b0_00_01_00_0) begin n_fail++; $display("FAIL rst_first_resp: ctl got %b expected %b", ctl, 8'b0_00_01_00_0); end
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_error_write();
    test_same_cycle();
    test_drop_req();
    test_stall();
    test_back_to_back();
    test_reset_in_resp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
